// File: rtl/sensor_display_sequencer_if.sv
// rtl/sensor_display_sequencer_if.sv - sample handshake and display bus for sensor_display_sequencer
//
// Signals:
//   rh_raw, temp_raw  raw sensor pair (producer -> sequencer)
//   sample_valid      raw pair valid this cycle
//   sample_ready      sequencer can accept a pair this cycle
//   RH_Value          committed RH, 4 BCD digits
//   Temp_Value        committed temperature, 4 BCD digits
//   disp_update       one-cycle pulse announcing a display change
//   busy              sequencer not idle
// Modports: master = sensor/display side, slave = sequencer.

interface sensor_display_sequencer_if;
    logic [15:0] rh_raw;
    logic [15:0] temp_raw;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] RH_Value;
    logic [15:0] Temp_Value;
    logic        disp_update;
    logic        busy;

    modport master (
        output rh_raw, temp_raw, sample_valid,
        input  sample_ready, RH_Value, Temp_Value, disp_update, busy
    );

    modport slave (
        input  rh_raw, temp_raw, sample_valid,
        output sample_ready, RH_Value, Temp_Value, disp_update, busy
    );
endinterface

// File: rtl/sensor_display_sequencer.sv
// rtl/sensor_display_sequencer.sv - rate-limited binary-to-BCD sequencer feeding the seven-segment display
//
// Ports:
//   CLK100MHZ   system clock
//   CPU_RESETN  asynchronous active-low reset
//   sd_if       sensor_display_sequencer_if.slave (sample handshake in, BCD display words out)
// Parameters:
//   REFRESH_CYCLES  cycles held after each commit before the next sample is accepted (>= 1)
//   BCD_MAX         clamp ceiling for raw values
// Optional feature macro: SIGNED_TEMP_EN (two's complement temperature with minus glyph)

module sensor_display_sequencer #(
    parameter int unsigned REFRESH_CYCLES = 50000000,
    parameter int unsigned BCD_MAX        = 9999
) (
    input logic                       CLK100MHZ,
    input logic                       CPU_RESETN,
    sensor_display_sequencer_if.slave sd_if
);
    localparam int              TW           = $clog2(REFRESH_CYCLES + 1);
    localparam logic [15:0]     MAX16        = 16'(BCD_MAX);
    localparam logic [TW-1:0]   REFRESH_LOAD = TW'(REFRESH_CYCLES);
    localparam logic [TW-1:0]   TIMER_ONE    = TW'(1);

    typedef enum logic [2:0] {IDLE, CONV_RH, CONV_TEMP, COMMIT, HOLD} state_t;

    state_t        state_q;
    logic [15:0]   bcd_q;
    logic [15:0]   bin_q;
    logic [15:0]   rh_bcd_q;
    logic [15:0]   temp_bin_q;
    logic [3:0]    cnt_q;
    logic [TW-1:0] timer_q;
    logic [15:0]   rh_value_q;
    logic [15:0]   temp_value_q;
    logic          sample_ready_q;
    logic          busy_q;
    logic          disp_update_q;

    logic [15:0]   rh_clamp_d;
    logic [15:0]   temp_clamp_d;
    logic [15:0]   bcd_adj_d;
    logic [15:0]   bcd_d;
    logic [15:0]   bin_d;
    logic [15:0]   temp_word_d;

`ifdef SIGNED_TEMP_EN
    logic          neg_q;
    logic          temp_neg_d;
    logic [15:0]   temp_mag_d;
`endif

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        rh_clamp_d = (sd_if.rh_raw > MAX16) ? MAX16 : sd_if.rh_raw;
`ifdef SIGNED_TEMP_EN
        temp_neg_d = sd_if.temp_raw[15];
        temp_mag_d = temp_neg_d ? (16'd0 - sd_if.temp_raw) : sd_if.temp_raw;
        // Only three digits remain once the leftmost one shows the minus glyph.
        if (temp_neg_d) begin
            temp_clamp_d = (temp_mag_d > 16'd999) ? 16'd999 : temp_mag_d;
        end else begin
            temp_clamp_d = (temp_mag_d > MAX16) ? MAX16 : temp_mag_d;
        end
        temp_word_d = neg_q ? {4'hF, bcd_q[11:0]} : bcd_q;
`else
        temp_clamp_d = (sd_if.temp_raw > MAX16) ? MAX16 : sd_if.temp_raw;
        temp_word_d  = bcd_q;
`endif
        // One double-dabble step: correct nibbles, then shift the next binary bit in.
        bcd_adj_d      = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        {bcd_d, bin_d} = {bcd_adj_d, bin_q} << 1;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q        <= IDLE;
            bcd_q          <= 16'h0000;
            bin_q          <= 16'h0000;
            rh_bcd_q       <= 16'h0000;
            temp_bin_q     <= 16'h0000;
            cnt_q          <= 4'd0;
            timer_q        <= '0;
            rh_value_q     <= 16'h0000;
            temp_value_q   <= 16'h0000;
            sample_ready_q <= 1'b1;
            busy_q         <= 1'b0;
            disp_update_q  <= 1'b0;
`ifdef SIGNED_TEMP_EN
            neg_q          <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (sd_if.sample_valid) begin
                        bin_q          <= rh_clamp_d;
                        temp_bin_q     <= temp_clamp_d;
                        bcd_q          <= 16'h0000;
                        cnt_q          <= 4'd15;
                        sample_ready_q <= 1'b0;
                        busy_q         <= 1'b1;
                        state_q        <= CONV_RH;
`ifdef SIGNED_TEMP_EN
                        neg_q          <= temp_neg_d;
`endif
                    end
                end
                CONV_RH: begin
                    if (cnt_q == 4'd0) begin
                        // Park the RH result and reuse the shifter for temperature.
                        rh_bcd_q <= bcd_d;
                        bcd_q    <= 16'h0000;
                        bin_q    <= temp_bin_q;
                        cnt_q    <= 4'd15;
                        state_q  <= CONV_TEMP;
                    end else begin
                        bcd_q <= bcd_d;
                        bin_q <= bin_d;
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                CONV_TEMP: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    disp_update_q <= 1'b1;
                    timer_q       <= REFRESH_LOAD;
                    state_q       <= HOLD;
                end
                HOLD: begin
                    // Both words land together on the edge that ends the update pulse.
                    if (disp_update_q) begin
                        rh_value_q    <= rh_bcd_q;
                        temp_value_q  <= temp_word_d;
                        disp_update_q <= 1'b0;
                    end
                    if (timer_q == TIMER_ONE) begin
                        timer_q        <= '0;
                        sample_ready_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= IDLE;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_if.sample_ready = sample_ready_q;
    assign sd_if.busy         = busy_q;
    assign sd_if.disp_update  = disp_update_q;
    assign sd_if.RH_Value     = rh_value_q;
    assign sd_if.Temp_Value   = temp_value_q;

endmodule

// File: doc/sensor_display_sequencer.md
Name: sensor_display_sequencer

Overview:
Rate-limited sequencer between the humidity/temperature sensor interface and the 8-digit seven-segment multiplexer. It accepts one raw binary sample pair through a valid/ready handshake and clamps each value. It converts each value serially to 4-digit BCD using shift-add-3 (double dabble), then commits both words atomically to the display inputs. It holds them for a programmable refresh interval before accepting the next sample, so the display never shows a half-updated or flickering value.

Parameters:
REFRESH_CYCLES, 50000000, clock cycles spent in HOLD after each commit (0.5 s at 100 MHz); legal range is >= 1.
BCD_MAX, 9999, clamp ceiling applied to each unsigned raw value before conversion.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz.
CPU_RESETN  input  1  asynchronous, active-low reset.
rh_raw  input  16  unsigned relative-humidity reading.
temp_raw  input  16  temperature reading; unsigned, or two's complement when SIGNED_TEMP_EN is defined.
sample_valid  input  1  raw pair is valid this cycle.
sample_ready  output  1  block can accept a pair this cycle.
RH_Value  output  16  committed RH as 4 BCD digits; [15:12] is the most significant digit.
Temp_Value  output  16  committed temperature as 4 BCD digits.
disp_update  output  1  one-cycle pulse when RH_Value/Temp_Value change.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (CPU_RESETN=0, asynchronous) forces the following, regardless of the current state:
  - state=IDLE
  - RH_Value=16'h0000, Temp_Value=16'h0000
  - disp_update=0, busy=0, sample_ready=1
  - conversion shift registers, bit counter and refresh timer cleared
- Reset asserted mid-conversion or mid-HOLD discards all work in progress; no partial commit occurs.
- States: IDLE -> CONV_RH -> CONV_TEMP -> COMMIT -> HOLD -> IDLE.
- IDLE:
  - sample_ready=1.
  - A handshake happens on a rising edge with sample_valid=1. On that edge, latch min(rh_raw, BCD_MAX) and min(temp_raw, BCD_MAX), load bit counter=15, and go to CONV_RH.
- CONV_RH: 16 cycles, one input bit per cycle, MSB first.
  - Each cycle, first add 3 to every BCD nibble that is >= 5.
  - Then shift {bcd[15:0], bin[15:0]} left by 1.
  - Exit to CONV_TEMP after the cycle where the counter reads 0.
- CONV_TEMP: identical 16-cycle conversion of the temperature value.
- COMMIT: one cycle.
  - RH_Value and Temp_Value load on the same edge; the two words never update separately.
  - disp_update=1 for exactly this one cycle.
- HOLD:
  - Timer counts REFRESH_CYCLES down to 1, then the block returns to IDLE.
  - sample_ready=0, so sample_valid is ignored and no request is queued.
- Latency:
  - Handshake edge N; outputs change on edge N+34.
  - disp_update is high during the cycle following edge N+33, until edge N+34.
  - The next handshake is possible no earlier than edge N+34+REFRESH_CYCLES.
- Outputs are registered and stable outside COMMIT.
- sample_ready=0 in every state except IDLE.
- Raw inputs are sampled only on the handshake edge; later changes have no effect on the conversion in progress.
- Boundaries:
  - Raw value 0 converts to 16'h0000.
  - Raw values 9999 and 65535 both convert to 16'h9999.
  - REFRESH_CYCLES=1 gives a HOLD of exactly one cycle.
  - sample_valid held high continuously accepts a new pair on every IDLE entry.

Optional Feature:
Macro: SIGNED_TEMP_EN.
- Defined:
  - temp_raw is two's complement.
  - If temp_raw[15]=1, the magnitude (-temp_raw) is clamped to 999 and converted. Temp_Value[15:12] is forced to 4'hF (minus glyph on the leftmost digit) and [11:0] holds 3 BCD digits.
  - Non-negative values are clamped to BCD_MAX as usual.
- Undefined:
  - temp_raw is unsigned, with no sign handling and no sign-related logic.

Test Plan:
- Reset release, no sample_valid -> RH_Value=16'h0000, Temp_Value=16'h0000, sample_ready=1, busy=0, disp_update never pulses.
- rh_raw=16'd1234, temp_raw=16'd567, single valid cycle -> 34 edges later RH_Value=16'h1234, Temp_Value=16'h0567, exactly one disp_update pulse.
- rh_raw=16'hFFFF, temp_raw=16'd9999 -> RH_Value=16'h9999, Temp_Value=16'h9999.
- REFRESH_CYCLES=100, sample_valid held high, inputs changing each cycle -> commits spaced exactly 134 cycles apart; each commit reflects the inputs at its own handshake edge.
- Assert CPU_RESETN=0 during CONV_TEMP after a prior commit of 16'h0042/16'h0021 -> outputs go to 0 immediately, no disp_update pulse, next sample converts correctly.
- With SIGNED_TEMP_EN: temp_raw=16'hFFFF -> Temp_Value=16'hF001; temp_raw=-16'd1500 -> 16'hF999; temp_raw=16'd250 -> 16'h0250.
